// File: rtl/fetch_queue.sv
// Instruction-fetch queue: issues imem reads at pc, tags them with their pc and
// buffers in-order responses for decode. A redirect drops any stale responses still in flight.
module fetch_queue #(
   parameter int XLEN     = 32,
   parameter int FQ_DEPTH = 2,
   parameter int CNT_W    = 2
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [XLEN-1:0]  pc_i,
   input  logic             flush_i,
   output logic             pc_adv_o,
   output logic             imem_req_o,
   output logic [XLEN-1:0]  imem_addr_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   input  logic [31:0]      imem_rdata_i,
   output logic             if_valid_o,
   output logic [XLEN-1:0]  if_pc_o,
   output logic [31:0]      if_instr_o,
   input  logic             if_ready_i
);

   localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;
   localparam logic [CNT_W:0] DEPTH_C = (CNT_W+1)'(FQ_DEPTH);

   logic [XLEN-1:0]  fifo_pc_q    [FQ_DEPTH];
   logic [31:0]      fifo_instr_q [FQ_DEPTH];
   logic [XLEN-1:0]  tag_q        [FQ_DEPTH];

   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_out_q, cnt_out_d, cnt_drop_q, cnt_drop_d;

   logic [CNT_W:0]   inflight;
   logic             issue;
   logic             rsp_keep;
   logic             pop;

   // Credits come from registered counts only, so a pop frees a slot one cycle later.
   assign inflight    = {1'b0, cnt_q} + {1'b0, cnt_out_q};
   assign imem_req_o  = !rst_i && !flush_i && (inflight < DEPTH_C);
   assign imem_addr_o = pc_i;
   assign issue       = imem_req_o && imem_gnt_i;
   assign pc_adv_o    = !rst_i && (issue || flush_i);

   assign rsp_keep    = imem_rvalid_i && (cnt_drop_q == '0) && !flush_i;
   assign if_valid_o  = !rst_i && (cnt_q != '0);
   assign pop         = if_valid_o && if_ready_i && !flush_i;
   assign if_pc_o     = fifo_pc_q[rd_ptr_q];
   assign if_instr_o  = fifo_instr_q[rd_ptr_q];

   always_comb begin
      tag_wr_d  = tag_wr_q + PTR_W'(issue);
      tag_rd_d  = tag_rd_q + PTR_W'(imem_rvalid_i);
      cnt_out_d = cnt_out_q + CNT_W'(issue) - CNT_W'(imem_rvalid_i);
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      cnt_d     = cnt_q;
      cnt_drop_d = cnt_drop_q;
      if (flush_i) begin
         // Everything still outstanding after this edge belongs to the old path.
         cnt_drop_d = cnt_out_q - CNT_W'(imem_rvalid_i);
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         cnt_d      = '0;
      end else begin
         if (imem_rvalid_i && (cnt_drop_q != '0))
            cnt_drop_d = cnt_drop_q - CNT_W'(1);
         wr_ptr_d = wr_ptr_q + PTR_W'(rsp_keep);
         rd_ptr_d = rd_ptr_q + PTR_W'(pop);
         cnt_d    = cnt_q + CNT_W'(rsp_keep) - CNT_W'(pop);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         tag_wr_q   <= '0;
         tag_rd_q   <= '0;
         cnt_q      <= '0;
         cnt_out_q  <= '0;
         cnt_drop_q <= '0;
         for (int i = 0; i < FQ_DEPTH; i++) begin
            fifo_pc_q[i]    <= '0;
            fifo_instr_q[i] <= '0;
            tag_q[i]        <= '0;
         end
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         tag_wr_q   <= tag_wr_d;
         tag_rd_q   <= tag_rd_d;
         cnt_q      <= cnt_d;
         cnt_out_q  <= cnt_out_d;
         cnt_drop_q <= cnt_drop_d;
         if (issue)
            tag_q[tag_wr_q] <= pc_i;
         if (rsp_keep) begin
            fifo_pc_q[wr_ptr_q]    <= tag_q[tag_rd_q];
            fifo_instr_q[wr_ptr_q] <= imem_rdata_i;
         end
      end
   end

   a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
      !(imem_rvalid_i && (cnt_out_q == '0)));

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: cycle vectors with expected handshake outputs, plus an
// imem/PC-register model feeding a scoreboard of expected {pc, instr} deliveries.
module tb_fetch_queue;
   logic        clk = 1'b0;
   logic        rst, flush, gnt, rdy, rvalid;
   logic [31:0] pc, rdata;
   logic        pc_adv, imem_req, if_valid;
   logic [31:0] imem_addr, if_pc, if_instr;

   always #5 clk = ~clk;

   fetch_queue #(.XLEN(32), .FQ_DEPTH(2), .CNT_W(2)) dut (
      .clk_i(clk), .rst_i(rst), .pc_i(pc), .flush_i(flush), .pc_adv_o(pc_adv),
      .imem_req_o(imem_req), .imem_addr_o(imem_addr), .imem_gnt_i(gnt),
      .imem_rvalid_i(rvalid), .imem_rdata_i(rdata), .if_valid_o(if_valid),
      .if_pc_o(if_pc), .if_instr_o(if_instr), .if_ready_i(rdy));

   typedef struct {logic [31:0] addr; int due;} pend_t;
   typedef struct {logic [31:0] pc; logic [31:0] instr;} exp_t;
   typedef struct {
      int seg; bit rst, flush, gnt, rdy;
      bit e_req, e_adv, e_valid, chk_addr; logic [31:0] e_addr;
   } vec_t;

   pend_t pend_q[$];
   exp_t  exp_q[$];
   vec_t  vecs[$];
   int    total = 0, passed = 0;
   int    cyc = 0, lat = 1;
   logic [31:0] target = 32'h100;
   logic        s_req, s_adv, s_valid;
   logic [31:0] s_addr, s_pc, s_instr;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'hA5A5_0F0F;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   function automatic void add(input int seg, input bit r, input bit f, input bit g, input bit rd,
                               input bit eq, input bit ea, input bit ev, input bit ca,
                               input logic [31:0] addr);
      vec_t v;
      v.seg = seg; v.rst = r; v.flush = f; v.gnt = g; v.rdy = rd;
      v.e_req = eq; v.e_adv = ea; v.e_valid = ev; v.chk_addr = ca; v.e_addr = addr;
      vecs.push_back(v);
   endfunction

   // One clock: sample at negedge, score deliveries, then step the imem and PC-register models.
   task automatic cycle();
      exp_t e;
      @(negedge clk);
      s_req = imem_req; s_adv = pc_adv; s_valid = if_valid;
      s_addr = imem_addr; s_pc = if_pc; s_instr = if_instr;
      if (rst || flush) exp_q.delete();
      else begin
         if (s_valid && rdy) begin
            if (exp_q.size() == 0) begin
               total++;
               $display("FAIL sb_unexpected: got pc %h expected no delivery", s_pc);
            end else begin
               e = exp_q.pop_front();
               chk("sb_pc", s_pc, e.pc);
               chk("sb_instr", s_instr, e.instr);
            end
         end
         if (s_req && gnt) exp_q.push_back('{pc, memf(pc)});
      end
      @(posedge clk); #1;
      if (rst) pend_q.delete();
      else begin
         if (rvalid) pend_q.delete(0);
         if (s_req && gnt) pend_q.push_back('{pc, cyc + lat});
      end
      if (rst) pc = 32'h0;
      else if (s_adv) pc = flush ? target : pc + 32'd4;
      cyc++;
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
         rvalid = 1'b1; rdata = memf(pend_q[0].addr);
      end else begin
         rvalid = 1'b0; rdata = 32'h0;
      end
   endtask

   task automatic run_seg(input int seg);
      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].seg == seg) begin
            rst = vecs[i].rst; flush = vecs[i].flush; gnt = vecs[i].gnt; rdy = vecs[i].rdy;
            cycle();
            chk($sformatf("s%0d_v%0d_req", seg, i), 32'(s_req), 32'(vecs[i].e_req));
            chk($sformatf("s%0d_v%0d_adv", seg, i), 32'(s_adv), 32'(vecs[i].e_adv));
            chk($sformatf("s%0d_v%0d_valid", seg, i), 32'(s_valid), 32'(vecs[i].e_valid));
            if (vecs[i].chk_addr)
               chk($sformatf("s%0d_v%0d_addr", seg, i), s_addr, vecs[i].e_addr);
         end
      end
      flush = 1'b0; rst = 1'b0;
   endtask

   task automatic idle(input int n, input bit g, input bit rd);
      gnt = g; rdy = rd; flush = 1'b0; rst = 1'b0;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; gnt = 1'b1; rdy = 1'b0;
      rvalid = 1'b0; rdata = 32'h0; pc = 32'h0;

      // seg 0: reset, backpressure to two credits, drain, then a 3-cycle gnt stall at 0x10
      add(0, 1,0,1,0, 0,0,0, 0, 32'h0);
      add(0, 1,0,1,0, 0,0,0, 0, 32'h0);
      add(0, 0,0,1,0, 1,1,0, 1, 32'h0);
      add(0, 0,0,1,0, 1,1,0, 1, 32'h4);
      add(0, 0,0,1,0, 0,0,1, 0, 32'h0);
      add(0, 0,0,1,0, 0,0,1, 0, 32'h0);
      add(0, 0,0,1,0, 0,0,1, 0, 32'h0);
      add(0, 0,0,1,1, 0,0,1, 0, 32'h0);
      add(0, 0,0,1,1, 1,1,1, 1, 32'h8);
      add(0, 0,0,1,1, 1,1,0, 1, 32'hC);
      add(0, 0,0,0,1, 0,0,1, 0, 32'h0);
      add(0, 0,0,0,1, 1,0,1, 1, 32'h10);
      add(0, 0,0,0,1, 1,0,0, 1, 32'h10);
      add(0, 0,0,0,1, 1,0,0, 1, 32'h10);
      add(0, 0,0,1,1, 1,1,0, 1, 32'h10);
      add(0, 0,0,0,1, 1,0,0, 1, 32'h14);
      add(0, 0,0,0,1, 1,0,1, 1, 32'h14);
      add(0, 0,0,0,1, 1,0,0, 1, 32'h14);
      // seg 1/2: two reads in flight (latency 2), flush while the first returns
      add(1, 0,0,1,1, 1,1,0, 1, 32'h20);
      add(1, 0,0,1,1, 1,1,0, 1, 32'h24);
      add(1, 0,1,1,1, 0,1,0, 0, 32'h0);
      add(2, 0,0,1,1, 1,1,0, 1, 32'h100);
      add(2, 0,0,1,1, 1,1,0, 1, 32'h104);
      add(2, 0,0,1,1, 0,0,0, 0, 32'h0);
      add(2, 0,0,1,1, 0,0,1, 0, 32'h0);
      add(2, 0,0,1,1, 1,1,1, 1, 32'h108);
      // seg 3/4: fill one entry + one outstanding, then reset
      add(3, 0,0,1,0, 1,1,0, 1, 32'h10C);
      add(3, 0,0,1,0, 1,1,0, 1, 32'h110);
      add(3, 0,0,1,0, 0,0,0, 0, 32'h0);
      add(4, 1,0,1,0, 0,0,0, 0, 32'h0);
      // seg 5: clean restart from pc 0
      add(5, 0,0,1,1, 1,1,0, 1, 32'h0);
      add(5, 0,0,1,1, 1,1,0, 1, 32'h4);
      add(5, 0,0,1,1, 0,0,1, 0, 32'h0);

      run_seg(0);

      lat = 1;
      idle(15, 1'b1, 1'b1);
      idle(6, 1'b0, 1'b1);
      chk("stream_drained", 32'(exp_q.size()), 32'd0);
      chk("stream_fifo_empty", 32'(dut.cnt_q), 32'd0);

      pc = 32'h20; lat = 2;
      run_seg(1);
      chk("flush_drop", 32'(dut.cnt_drop_q), 32'd1);
      chk("flush_out", 32'(dut.cnt_out_q), 32'd1);
      chk("flush_cnt", 32'(dut.cnt_q), 32'd0);
      run_seg(2);
      idle(6, 1'b0, 1'b1);
      chk("flush_drained", 32'(exp_q.size()), 32'd0);

      pc = 32'h10C;
      run_seg(3);
      chk("prerst_cnt", 32'(dut.cnt_q), 32'd1);
      chk("prerst_out", 32'(dut.cnt_out_q), 32'd1);
      run_seg(4);
      chk("rst_valid", 32'(if_valid), 32'd0);
      chk("rst_cnt", 32'(dut.cnt_q), 32'd0);
      chk("rst_out", 32'(dut.cnt_out_q), 32'd0);
      chk("rst_drop", 32'(dut.cnt_drop_q), 32'd0);

      lat = 1;
      run_seg(5);
      idle(8, 1'b1, 1'b1);
      idle(6, 1'b0, 1'b1);
      chk("final_drained", 32'(exp_q.size()), 32'd0);
      chk("final_valid", 32'(if_valid), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
